// File: rtl/div_iter_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_iter_unit_pkg
// Shared definitions for the iterative MIPS DIV/DIVU unit:
//   - operand width and iteration-counter width
//   - FSM state encoding (IDLE / BUSY / DONE)
//   - quotient value reported for a divide by zero
// -----------------------------------------------------------------------------
package div_iter_unit_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 5;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    // Restoring division with a zero divisor naturally yields all-ones; the
    // constant keeps that result explicit and independent of the signed fixup.
    localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage : div_iter_unit_pkg

// File: rtl/div_sign_fix.sv
// -----------------------------------------------------------------------------
// div_sign_fix
// Purely combinational sign handling around the unsigned divider core.
//   Entry side: magnitudes of dividend/divisor (only for signed DIV) and the
//               sign flags needed to restore the result later.
//   Exit side : negates the raw quotient/remainder according to stored flags.
// Ports
//   signed_div_i           1=DIV, 0=DIVU
//   a_i, b_i               raw dividend / divisor
//   a_abs_o, b_abs_o       operand magnitudes fed to the core
//   quot_neg_o, rem_neg_o  quotient / remainder must be negated on exit
//   quot_neg_i, rem_neg_i  latched flags for the operation in flight
//   quot_raw_i, rem_raw_i  unsigned core results
//   quot_o, rem_o          sign-corrected results
// -----------------------------------------------------------------------------
module div_sign_fix
    import div_iter_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             signed_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] a_abs_o,
    output logic [WIDTH-1:0] b_abs_o,
    output logic             quot_neg_o,
    output logic             rem_neg_o,
    input  logic             quot_neg_i,
    input  logic             rem_neg_i,
    input  logic [WIDTH-1:0] quot_raw_i,
    input  logic [WIDTH-1:0] rem_raw_i,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Two's complement negate with wrap: -0x80000000 stays 0x80000000, which
    // is exactly the magnitude the unsigned core needs for the most negative value.
    function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] v);
        return (~v) + ONE;
    endfunction

    logic a_is_neg_s;
    logic b_is_neg_s;

    assign a_is_neg_s = signed_div_i & a_i[WIDTH-1];
    assign b_is_neg_s = signed_div_i & b_i[WIDTH-1];

    // Entry: magnitudes and result sign flags
    always_comb begin
        a_abs_o    = a_is_neg_s ? neg2c(a_i) : a_i;
        b_abs_o    = b_is_neg_s ? neg2c(b_i) : b_i;
        quot_neg_o = a_is_neg_s ^ b_is_neg_s;
        rem_neg_o  = a_is_neg_s;
    end

    // Exit: restore signs on the unsigned core results
    always_comb begin
        quot_o = quot_neg_i ? neg2c(quot_raw_i) : quot_raw_i;
        rem_o  = rem_neg_i  ? neg2c(rem_raw_i)  : rem_raw_i;
    end

endmodule : div_sign_fix

// File: rtl/div_iter_unit.sv
// -----------------------------------------------------------------------------
// div_iter_unit
// Iterative radix-2 restoring divider for MIPS DIV/DIVU in the execute stage.
// One quotient bit per cycle; holds the pipeline through div_stall until the
// quotient (LO) and remainder (HI) are ready, then presents them with res_valid
// until the rest of the pipeline is free to accept them.
// Ports
//   clk, rst     core clock, synchronous active-high reset
//   flush        exception flush, aborts any operation
//   start        DIV/DIVU valid in E stage
//   signed_div   1=DIV, 0=DIVU (sampled with start)
//   a, b         dividend / divisor
//   ext_stall    stall from other pipeline sources
//   div_stall    stall request to the hazard unit
//   res_valid    quot/rem valid; HI/LO written when res_valid & ~ext_stall
//   quot, rem    quotient / remainder
// -----------------------------------------------------------------------------
module div_iter_unit
    import div_iter_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ext_stall,
    output logic             div_stall,
    output logic             res_valid,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    div_state_e       state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [WIDTH-1:0] acc_rem_q,  acc_rem_d;   // upper half of shift accumulator
    logic [WIDTH-1:0] acc_dvd_q,  acc_dvd_d;   // lower half: dividend out, quotient in
    logic [WIDTH-1:0] dvs_q,      dvs_d;       // divisor magnitude
    logic             quot_neg_q, quot_neg_d;
    logic             rem_neg_q,  rem_neg_d;
    logic             div0_q,     div0_d;
    logic [WIDTH-1:0] quot_q,     quot_d;
    logic [WIDTH-1:0] rem_q,      rem_d;

    logic [WIDTH-1:0] a_abs_s;
    logic [WIDTH-1:0] b_abs_s;
    logic             quot_neg_s;
    logic             rem_neg_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   trial_s;
    logic             no_borrow_s;
    logic [WIDTH-1:0] step_rem_s;
    logic [WIDTH-1:0] step_dvd_s;
    logic [WIDTH-1:0] fix_quot_s;
    logic [WIDTH-1:0] fix_rem_s;
    logic             div_stall_s;

    // The exit fixup looks at this cycle's step result so the final iteration
    // can register the corrected quotient/remainder directly on entry to DONE.
    div_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .signed_div_i (signed_div),
        .a_i          (a),
        .b_i          (b),
        .a_abs_o      (a_abs_s),
        .b_abs_o      (b_abs_s),
        .quot_neg_o   (quot_neg_s),
        .rem_neg_o    (rem_neg_s),
        .quot_neg_i   (quot_neg_q),
        .rem_neg_i    (rem_neg_q),
        .quot_raw_i   (step_dvd_s),
        .rem_raw_i    (step_rem_s),
        .quot_o       (fix_quot_s),
        .rem_o        (fix_rem_s)
    );

    // One restoring step: shift the accumulator left, trial-subtract divisor.
    // The partial remainder is always below the divisor, so WIDTH+1 bits suffice.
    always_comb begin
        shifted_s   = {acc_rem_q, acc_dvd_q[WIDTH-1]};
        trial_s     = shifted_s - {1'b0, dvs_q};
        no_borrow_s = ~trial_s[WIDTH];
        if (no_borrow_s) begin
            step_rem_s = trial_s[WIDTH-1:0];
        end else begin
            step_rem_s = shifted_s[WIDTH-1:0];
        end
        step_dvd_s = {acc_dvd_q[WIDTH-2:0], no_borrow_s};
    end

    // FSM next state, datapath next values and stall request
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_rem_d   = acc_rem_q;
        acc_dvd_d   = acc_dvd_q;
        dvs_d       = dvs_q;
        quot_neg_d  = quot_neg_q;
        rem_neg_d   = rem_neg_q;
        div0_d      = div0_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        div_stall_s = 1'b0;

        case (state_q)
            DIV_IDLE: begin
                if (start & ~flush) begin
                    div_stall_s = 1'b1;
                    state_d     = DIV_BUSY;
                    cnt_d       = {CNT_W{1'b0}};
                    acc_rem_d   = {WIDTH{1'b0}};
                    acc_dvd_d   = a_abs_s;
                    dvs_d       = b_abs_s;
                    quot_neg_d  = quot_neg_s;
                    rem_neg_d   = rem_neg_s;
                    div0_d      = (b == {WIDTH{1'b0}});
                end else begin
                    state_d = DIV_IDLE;
                end
            end

            DIV_BUSY: begin
                if (flush) begin
                    state_d = DIV_IDLE;
                end else begin
                    div_stall_s = 1'b1;
                    acc_rem_d   = step_rem_s;
                    acc_dvd_d   = step_dvd_s;
                    cnt_d       = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = DIV_DONE;
                        // Remainder fixup turns |a| back into a, which is the
                        // required divide-by-zero remainder for DIV as well.
                        if (div0_q) begin
                            quot_d = DIV_BY_ZERO_QUOT;
                        end else begin
                            quot_d = fix_quot_s;
                        end
                        rem_d = fix_rem_s;
                    end else begin
                        state_d = DIV_BUSY;
                    end
                end
            end

            DIV_DONE: begin
                // start is ignored here: the same instruction is still in E.
                if (flush | ~ext_stall) begin
                    state_d = DIV_IDLE;
                end else begin
                    state_d = DIV_DONE;
                end
            end

            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            acc_rem_q  <= {WIDTH{1'b0}};
            acc_dvd_q  <= {WIDTH{1'b0}};
            dvs_q      <= {WIDTH{1'b0}};
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            div0_q     <= 1'b0;
            quot_q     <= {WIDTH{1'b0}};
            rem_q      <= {WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_rem_q  <= acc_rem_d;
            acc_dvd_q  <= acc_dvd_d;
            dvs_q      <= dvs_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            div0_q     <= div0_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
        end
    end

    // div_stall must be combinational so the hazard unit sees it in the start
    // cycle; res_valid is masked by flush so an aborted result never reaches HI/LO.
    assign div_stall = div_stall_s;
    assign res_valid = (state_q == DIV_DONE) & ~flush;
    assign quot      = quot_q;
    assign rem       = rem_q;

endmodule : div_iter_unit
